lcb_enable_ctrl: RTL and testbench

Sequencer and arbiter for a gated local-clock-buffer (LCB) domain, such as the DFF bank fed by an `INV_Z80`-style LCB. It wakes the LCB on demand and grants the gated flop bank to one of `NREQ` requesters at a time, round-robin. It rotates ownership after a hold limit and shuts the LCB off after an idle period. It sits between the requesting control logic and the LCB enable pin, inside the same gate-level netlist flow.

---
 rtl/lcb_enable_ctrl.sv | 135 +++++++++++++
 tb/tb_lcb_enable_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lcb_enable_ctrl.sv
// lcb_enable_ctrl: wakes a gated LCB on demand and round-robin grants its flop bank to NREQ requesters.
// Optional macro LCB_IDLE_TIMEOUT_EN: IDLE waits IDLE_CYC quiet cycles before turning the LCB off.
module lcb_enable_ctrl #(
    parameter int NREQ     = 4,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic            iccad_clk,
    input  logic            iccad_rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            lcb_en,
    output logic            busy
);
    localparam int MAX_WH = (WAKE_CYC > HOLD_MAX) ? WAKE_CYC : HOLD_MAX;
    localparam int MAXC   = (MAX_WH > IDLE_CYC) ? MAX_WH : IDLE_CYC;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int PW     = $clog2(NREQ);

    typedef enum logic [1:0] {OFF, WAKE, GRANT, IDLE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            lcb_en_q, busy_q;
    logic [NREQ-1:0] win;
    logic [PW-1:0]   win_idx, idx;
    logic            found;

    // Round-robin search starts just past the last owner, so the owner itself is tried last.
    always_comb begin
        win     = '0;
        win_idx = ptr_q;
        idx     = '0;
        found   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr_q) + i) % NREQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                win      = '0;
                win[idx] = 1'b1;
                win_idx  = idx;
            end
        end
    end

    // One counter serves wake, hold and idle timing since those phases never overlap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            OFF: begin
                if (|req) begin
                    state_d = WAKE;
                    cnt_d   = CW'(1);
                end
            end
            WAKE: begin
                if (cnt_q != CW'(WAKE_CYC)) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (|req) begin
                    state_d = GRANT;
                    gnt_d   = win;
                    ptr_d   = win_idx;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = CW'(1);
                end
            end
            GRANT: begin
                if (|(req & gnt_q)) begin
                    if (cnt_q == CW'(HOLD_MAX) && |(req & ~gnt_q)) begin
                        gnt_d = win;
                        ptr_d = win_idx;
                        cnt_d = CW'(1);
                    end else if (cnt_q != CW'(HOLD_MAX)) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (|req) begin
                    gnt_d = win;
                    ptr_d = win_idx;
                    cnt_d = CW'(1);
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = CW'(1);
                end
            end
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    gnt_d   = win;
                    ptr_d   = win_idx;
                    cnt_d   = CW'(1);
                end else begin
`ifdef LCB_IDLE_TIMEOUT_EN
                    state_d = (cnt_q == CW'(IDLE_CYC)) ? OFF : IDLE;
                    cnt_d   = (cnt_q == CW'(IDLE_CYC)) ? '0 : cnt_q + CW'(1);
`else
                    state_d = OFF;
                    cnt_d   = '0;
`endif
                end
            end
            default: state_d = OFF;
        endcase
    end

    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            ptr_q    <= PW'(NREQ - 1);
            gnt_q    <= '0;
            lcb_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            lcb_en_q <= (state_d != OFF);
            busy_q   <= (state_d != OFF);
        end
    end

    assign gnt    = gnt_q;
    assign lcb_en = lcb_en_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_lcb_enable_ctrl.sv
// tb_lcb_enable_ctrl: scoreboard bench for lcb_enable_ctrl against a behavioural model.
// Honours LCB_IDLE_TIMEOUT_EN the same way as the design.
module tb_lcb_enable_ctrl;
    localparam int NREQ     = 4;
    localparam int WAKE_CYC = 2;
    localparam int IDLE_CYC = 8;
    localparam int HOLD_MAX = 16;
`ifdef LCB_IDLE_TIMEOUT_EN
    localparam int IDLE_LIM = IDLE_CYC;
`else
    localparam int IDLE_LIM = 1;
`endif

    logic            iccad_clk   = 1'b0;
    logic            iccad_rst_n = 1'b1;
    logic [NREQ-1:0] req         = '0;
    logic [NREQ-1:0] gnt;
    logic            lcb_en, busy;

    typedef struct packed {
        logic [NREQ-1:0] g;
        logic            e;
        logic            b;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    bit m_on;
    int m_wake, m_owner, m_hold, m_idle, m_ptr;

    lcb_enable_ctrl #(.NREQ(NREQ), .WAKE_CYC(WAKE_CYC), .IDLE_CYC(IDLE_CYC), .HOLD_MAX(HOLD_MAX)) dut (
        .iccad_clk  (iccad_clk),
        .iccad_rst_n(iccad_rst_n),
        .req        (req),
        .gnt        (gnt),
        .lcb_en     (lcb_en),
        .busy       (busy)
    );

    always #5 iccad_clk = ~iccad_clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic void m_reset();
        m_on = 0; m_wake = 0; m_owner = -1; m_hold = 0; m_idle = 0; m_ptr = NREQ - 1;
    endfunction

    function automatic void m_grant(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int c = (m_ptr + k) % NREQ;
            if (r[c]) begin
                m_owner = c; m_ptr = c; m_hold = 1;
                return;
            end
        end
    endfunction

    // Model: LCB on/off, remaining wake cycles, current owner (-1 = none), quiet-cycle run length.
    function automatic void m_step(input logic [NREQ-1:0] r);
        if (!m_on) begin
            if (r != 0) begin m_on = 1; m_wake = WAKE_CYC; end
        end else if (m_wake > 0) begin
            m_wake--;
            if (m_wake == 0) begin
                if (r != 0) m_grant(r);
                else m_idle = 0;
            end
        end else if (m_owner >= 0) begin
            if (r[m_owner]) begin
                if (m_hold >= HOLD_MAX && (r & ~(NREQ'(1) << m_owner)) != 0) m_grant(r);
                else if (m_hold < HOLD_MAX) m_hold++;
            end else if (r != 0) m_grant(r);
            else begin m_owner = -1; m_idle = 0; end
        end else begin
            if (r != 0) m_grant(r);
            else begin
                m_idle++;
                if (m_idle >= IDLE_LIM) m_on = 0;
            end
        end
    endfunction

    task automatic step(input logic [NREQ-1:0] r);
        exp_t e;
        req = r;
        @(posedge iccad_clk);
        #1;
        m_step(r);
        e.g = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        e.e = m_on;
        e.b = m_on;
        q.push_back(e);
    endtask

    task automatic hold_req(input logic [NREQ-1:0] r, input int n);
        for (int i = 0; i < n; i++) step(r);
    endtask

    task automatic do_reset();
        q.delete();
        iccad_rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_lcb_en", lcb_en, 0);
        check("rst_busy", busy, 0);
        m_reset();
        @(posedge iccad_clk);
        #1;
        iccad_rst_n = 1'b1;
    endtask

    always @(negedge iccad_clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("gnt", gnt, e.g);
            check("lcb_en", lcb_en, e.e);
            check("busy", busy, e.b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end

    initial begin
        #2;
        do_reset();
        hold_req(4'b0001, 6);
        hold_req(4'b0000, 12);
        hold_req(4'b0101, 5);
        hold_req(4'b0100, 4);
        hold_req(4'b0011, 40);
        hold_req(4'b0000, 12);
        hold_req(4'b0001, 5);
        hold_req(4'b0000, 5);
        hold_req(4'b1000, 4);
        hold_req(4'b0000, 12);
        hold_req(4'b0110, 4);
        #2;
        do_reset();
        hold_req(4'b0010, 6);
        for (int b = 0; b < 300; b++) begin
            logic [NREQ-1:0] r;
            int len;
            r   = ($urandom_range(0, 9) < 4) ? '0 : NREQ'($urandom_range(1, 15));
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) r = NREQ'($urandom_range(0, 15));
                step(r);
            end
            if ($urandom_range(0, 39) == 0) begin
                #2;
                do_reset();
            end
        end
        req = '0;
        @(negedge iccad_clk);
        #1;
        check("drain", 8'(q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
